// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the dual-read register file.
// Module parameters default to these values; RESET_DATA is the cleared register/data value.
package reg_file_pkg;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_NUM_REGS = 8;
  localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

  typedef logic [DEFAULT_DATA_W-1:0] data_t;
  typedef logic [DEFAULT_ADDR_W-1:0] addr_t;

  localparam data_t RESET_DATA = '0;

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: handshake ready, optional write bypass (BYPASS_EN) and output register.
// Out-of-range addresses are never pending and read back as zero.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                             wire_clock,
  input  logic                             wire_reset,
  input  logic                             rd_req,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              pending,
  output logic                             rd_ready,
  output logic                             rd_valid,
  output logic [DATA_W-1:0]                rd_data
);

  logic              in_range;
  logic              pend_hit;
  logic              bypass_hit;
  logic              accept;
  logic [DATA_W-1:0] read_value;
  logic              rd_valid_d, rd_valid_q;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  assign in_range = (32'(rd_addr) < NUM_REGS);
  assign pend_hit = in_range && pending[rd_addr];

`ifdef BYPASS_EN
  assign bypass_hit = wr_en && (wr_addr == rd_addr) && in_range;
`else
  logic unused_bypass;
  assign bypass_hit    = 1'b0;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data};
`endif

  assign rd_ready = !rd_req || !pend_hit || bypass_hit;
  assign accept   = rd_req && rd_ready && !wire_reset;

  // A forwarded write takes priority over the stored register value
  always_comb begin
    read_value = DATA_W'(RESET_DATA);
    if (bypass_hit) begin
      read_value = wr_data;
    end else if (in_range) begin
      read_value = regs[rd_addr];
    end
  end

  always_comb begin
    rd_valid_d = accept;
    rd_data_d  = rd_data_q;
    if (accept) begin
      rd_data_d = read_value;
    end
  end

  always_ff @(posedge wire_clock) begin
    if (wire_reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= DATA_W'(RESET_DATA);
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/reg_file_dual_read.sv
// Register file with one write port, a pending scoreboard and two independent registered read ports.
// Define BYPASS_EN to forward same-cycle writes to reads (write-first); default is read-first.
module reg_file_dual_read
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
  input  logic                        wire_clock,
  input  logic                        wire_reset,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        pend_set,
  input  logic [$clog2(NUM_REGS)-1:0] pend_addr,
  input  logic                        rd_req_m3,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_m3,
  input  logic                        rd_req_m4,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_m4,
  output logic                        rd_ready_m3,
  output logic                        rd_ready_m4,
  output logic                        rd_valid_m3,
  output logic                        rd_valid_m4,
  output logic [DATA_W-1:0]           rd_data_m3,
  output logic [DATA_W-1:0]           rd_data_m4,
  output logic [NUM_REGS-1:0]         pending
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d, regs_q;
  logic [NUM_REGS-1:0]             pending_d, pending_q;
  logic                            wr_in_range;
  logic                            pend_in_range;

  assign wr_in_range   = (32'(wr_addr) < NUM_REGS);
  assign pend_in_range = (32'(pend_addr) < NUM_REGS);

  // pend_set is applied after the write so it wins on a shared address
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_en && wr_in_range) begin
      regs_d[wr_addr]    = wr_data;
      pending_d[wr_addr] = 1'b0;
    end
    if (pend_set && pend_in_range) begin
      pending_d[pend_addr] = 1'b1;
    end
  end

  always_ff @(posedge wire_clock) begin
    if (wire_reset) begin
      regs_q    <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

  reg_file_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_port_m3 (
    .wire_clock (wire_clock),
    .wire_reset (wire_reset),
    .rd_req     (rd_req_m3),
    .rd_addr    (rd_addr_m3),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .regs       (regs_q),
    .pending    (pending_q),
    .rd_ready   (rd_ready_m3),
    .rd_valid   (rd_valid_m3),
    .rd_data    (rd_data_m3)
  );

  reg_file_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_port_m4 (
    .wire_clock (wire_clock),
    .wire_reset (wire_reset),
    .rd_req     (rd_req_m4),
    .rd_addr    (rd_addr_m4),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .regs       (regs_q),
    .pending    (pending_q),
    .rd_ready   (rd_ready_m4),
    .rd_valid   (rd_valid_m4),
    .rd_data    (rd_data_m4)
  );

endmodule
